// File: rtl/tl_fsm_w_left.sv
// Two-street traffic-light controller with optional left-turn phases.
// q is the state register itself; a 4-bit dwell counter times every phase.
module tl_fsm_w_left #(
  parameter int MIN_GREEN  = 4,
  parameter int YELLOW_CYC = 2,
  parameter int LEFT_CYC   = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       Ta,
  input  logic       Tb,
  input  logic       La_req,
  input  logic       Lb_req,
  output logic [2:0] q
);

  typedef enum logic [2:0] {
    S0 = 3'b000,  // A green
    S1 = 3'b001,  // A yellow
    S2 = 3'b010,  // A left
    S3 = 3'b011,  // A yellow after left
    S4 = 3'b100,  // B green
    S5 = 3'b101,  // B yellow
    S6 = 3'b110,  // B left
    S7 = 3'b111   // B yellow after left
  } state_t;

  localparam logic [3:0] GREEN_LAST  = 4'(MIN_GREEN - 1);
  localparam logic [3:0] YELLOW_LAST = 4'(YELLOW_CYC - 1);
  localparam logic [3:0] LEFT_LAST   = 4'(LEFT_CYC - 1);

  state_t     state;
  logic [3:0] cnt;
  logic [3:0] dwell_last;

  always_comb begin
    dwell_last = YELLOW_LAST;
    case (state)
      S0, S4:  dwell_last = GREEN_LAST;
      S2, S6:  dwell_last = LEFT_LAST;
      default: dwell_last = YELLOW_LAST;
    endcase
  end

  // The counter stops at dwell_last, so green saturates there until its sensor drops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S0;
      cnt   <= 4'd0;
    end else if (cnt != dwell_last) begin
      cnt <= cnt + 4'd1;
    end else begin
      case (state)
        S0: if (!Ta) begin
          state <= S1;
          cnt   <= 4'd0;
        end
        S1: begin
          state <= La_req ? S2 : S4;
          cnt   <= 4'd0;
        end
        S2: begin
          state <= S3;
          cnt   <= 4'd0;
        end
        S3: begin
          state <= S4;
          cnt   <= 4'd0;
        end
        S4: if (!Tb) begin
          state <= S5;
          cnt   <= 4'd0;
        end
        S5: begin
          state <= Lb_req ? S6 : S0;
          cnt   <= 4'd0;
        end
        S6: begin
          state <= S7;
          cnt   <= 4'd0;
        end
        S7: begin
          state <= S0;
          cnt   <= 4'd0;
        end
        default: begin
          state <= S0;
          cnt   <= 4'd0;
        end
      endcase
    end
  end

  assign q = state;

endmodule

// File: tb/tb_tl_fsm_w_left.sv
// Directed bench for tl_fsm_w_left: a phase/elapsed-time model checked every
// cycle, plus hand-written light sequences for the key scenarios.
module tb_tl_fsm_w_left;

  localparam int MIN_GREEN  = 4;
  localparam int YELLOW_CYC = 2;
  localparam int LEFT_CYC   = 3;

  logic       clk;
  logic       reset_n;
  logic       Ta, Tb, La_req, Lb_req;
  logic [2:0] q;

  int total = 0;
  int bad   = 0;

  tl_fsm_w_left #(
    .MIN_GREEN (MIN_GREEN),
    .YELLOW_CYC(YELLOW_CYC),
    .LEFT_CYC  (LEFT_CYC)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .Ta     (Ta),
    .Tb     (Tb),
    .La_req (La_req),
    .Lb_req (Lb_req),
    .q      (q)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [2:0] got, input logic [2:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: q=%b expected %b at t=%0t", name, got, exp, $time);
    end
  endtask

  // Model: phase number plus unbounded count of cycles already spent in it.
  int m_phase = 0;
  int m_age   = 0;
  int m_done;
  int m_next;
  bit m_go;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_phase = 0;
      m_age   = 0;
    end else begin
      m_done = m_age + 1;
      m_go   = 1'b0;
      m_next = m_phase;
      case (m_phase)
        0: begin m_go = (m_done >= MIN_GREEN) && !Ta; m_next = 1; end
        1: begin m_go = (m_done == YELLOW_CYC); m_next = La_req ? 2 : 4; end
        2: begin m_go = (m_done == LEFT_CYC); m_next = 3; end
        3: begin m_go = (m_done == YELLOW_CYC); m_next = 4; end
        4: begin m_go = (m_done >= MIN_GREEN) && !Tb; m_next = 5; end
        5: begin m_go = (m_done == YELLOW_CYC); m_next = Lb_req ? 6 : 0; end
        6: begin m_go = (m_done == LEFT_CYC); m_next = 7; end
        default: begin m_go = (m_done == YELLOW_CYC); m_next = 0; end
      endcase
      if (m_go) begin
        m_phase = m_next;
        m_age   = 0;
      end else begin
        m_age = m_done;
      end
    end
  end

  always @(negedge clk) begin
    #1;
    chk("model", q, 3'(m_phase));
  end

  // Inputs change 2 time units after the falling edge, clear of both edges.
  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    chk("reset", q, 3'b000);
    tick();
    reset_n = 1'b1;
  endtask

  logic [2:0] exp_q[$];

  task automatic push(input logic [2:0] v, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(v);
  endtask

  // Sample index 0 is the current cycle; each later entry is one clock later.
  task automatic follow(input string name);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) tick();
      chk(name, q, exp_q[i]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b1;
    Ta = 1'b0; Tb = 1'b0; La_req = 1'b0; Lb_req = 1'b0;
    #1 reset_n = 1'b0;
    #1 chk("async_por", q, 3'b000);

    // Ta stuck high: A green forever, whatever Tb does.
    Ta = 1'b1;
    do_reset();
    for (int i = 0; i < 30; i++) begin
      chk("hold_a", q, 3'b000);
      tick();
      Tb = 1'($urandom_range(0, 1));
    end

    // Plain A cycle, no left turn; Tb high so B green holds.
    Ta = 1'b0; La_req = 1'b0; Tb = 1'b1;
    do_reset();
    exp_q.delete(); push(3'b000, 4); push(3'b001, 2); push(3'b100, 4);
    follow("a_plain");

    // A cycle with left turn.
    La_req = 1'b1;
    do_reset();
    exp_q.delete(); push(3'b000, 4); push(3'b001, 2); push(3'b010, 3);
    push(3'b011, 2); push(3'b100, 5);
    follow("a_left");

    // B cycle with left turn, back to A green.
    La_req = 1'b0; Tb = 1'b0; Lb_req = 1'b1;
    do_reset();
    exp_q.delete(); push(3'b000, 4); push(3'b001, 2); push(3'b100, 4);
    push(3'b101, 2); push(3'b110, 3); push(3'b111, 2); push(3'b000, 1);
    follow("b_left");

    // B cycle without left turn.
    Lb_req = 1'b0;
    do_reset();
    exp_q.delete(); push(3'b000, 4); push(3'b001, 2); push(3'b100, 4);
    push(3'b101, 2); push(3'b000, 1);
    follow("b_plain");

    // Asynchronous reset in the middle of the A left phase.
    Ta = 1'b0; La_req = 1'b1; Tb = 1'b1;
    do_reset();
    exp_q.delete(); push(3'b000, 4); push(3'b001, 2); push(3'b010, 2);
    follow("pre_abort");
    #1 reset_n = 1'b0;
    #1 chk("async_mid", q, 3'b000);
    La_req = 1'b0;
    tick();
    chk("async_held", q, 3'b000);
    tick();
    reset_n = 1'b1;
    exp_q.delete(); push(3'b000, 4); push(3'b001, 2); push(3'b100, 2);
    follow("post_abort");

    // Ta drops early: minimum green still honoured; only exit-cycle La_req counts.
    Ta = 1'b1; La_req = 1'b0; Tb = 1'b1;
    do_reset();
    chk("mg_c0", q, 3'b000);
    tick(); Ta = 1'b0;
    chk("mg_c1", q, 3'b000);
    tick(); chk("mg_c2", q, 3'b000);
    tick(); chk("mg_c3", q, 3'b000);
    tick(); chk("mg_y0", q, 3'b001); La_req = 1'b1;
    tick(); chk("mg_y1", q, 3'b001); La_req = 1'b0;
    tick(); chk("late_no", q, 3'b100);

    Ta = 1'b0; La_req = 1'b0;
    do_reset();
    exp_q.delete(); push(3'b000, 4); push(3'b001, 1);
    follow("pre_late");
    tick(); chk("late_y1", q, 3'b001); La_req = 1'b1;
    tick(); chk("late_yes", q, 3'b010); La_req = 1'b0;
    tick(); chk("late_l1", q, 3'b010);

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
